// File: rtl/axis_framer_if.sv
// AXI-Stream beat interface used on both sides of axis_framer.
//
// Signals:
//   tdata   payload, DATA_WIDTH bits
//   tvalid  source has a beat on tdata
//   tready  sink accepts the beat this cycle
//   tlast   end-of-packet marker travelling with the beat
//
// Modports:
//   master  drives tdata/tvalid/tlast, samples tready
//   slave   samples tdata/tvalid/tlast, drives tready
interface axis_framer_if #(
  parameter int unsigned DATA_WIDTH = 32
);

  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );

endinterface

// File: rtl/axis_framer.sv
// axis_framer: AXI-Stream framing stage.
//
// Takes a raw beat stream and marks m_axis.tlast every pkt_len beats. An early
// s_axis.tlast from the source also ends the packet, in which case short_pkt
// pulses for one cycle. The output is one registered stage that sustains one
// beat per cycle while the downstream sink keeps tready high.
//
// Ports:
//   aclk       clock, everything on the rising edge
//   aresetn    asynchronous active-low reset
//   pkt_len    beats per packet, sampled on the first beat of each packet
//              (0 is treated as 1)
//   s_axis     slave stream: tdata/tvalid/tlast in, tready out
//   m_axis     master stream: tdata/tvalid/tlast out, tready in
//   short_pkt  one-cycle pulse, registered with the beat that ended a packet
//              early
//   pkt_count  (only with AXIS_FRAMER_STATS_EN) 32-bit wrapping count of
//              packets delivered downstream (m_axis handshakes with tlast)
//
// Build option:
//   AXIS_FRAMER_STATS_EN  adds the pkt_count port and its counter.
module axis_framer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [LEN_WIDTH-1:0] pkt_len,
  axis_framer_if.slave         s_axis,
  axis_framer_if.master        m_axis,
  output logic                 short_pkt
`ifdef AXIS_FRAMER_STATS_EN
  ,
  output logic [31:0]          pkt_count
`else
  // No statistics port in this build.
`endif
);

  // Two bits so that a corrupted encoding has somewhere to land and recover.
  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StInPkt = 2'b01
  } state_e;

  state_e                state_q, state_d;
  logic [LEN_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  eff_len;
  logic [DATA_WIDTH-1:0] tdata_q;
  logic                  tvalid_q;
  logic                  tlast_q;
  logic                  short_q, short_d;
  logic                  tlast_c;
  logic                  last_cnt;
  logic                  s_ready;
  logic                  s_hs;
  logic                  m_hs;

  // Ready is combinational so a beat can enter while the held one leaves.
  assign s_ready = aresetn && (!tvalid_q || m_axis.tready);
  assign s_hs    = s_axis.tvalid && s_ready;
  assign m_hs    = tvalid_q && m_axis.tready;

  assign s_axis.tready = s_ready;
  assign m_axis.tdata  = tdata_q;
  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tlast  = tlast_q;
  assign short_pkt     = short_q;

  assign eff_len  = (pkt_len == '0) ? LEN_WIDTH'(1) : pkt_len;
  assign last_cnt = (beat_cnt_q == (len_q - LEN_WIDTH'(1)));

  // Framing state machine; advances only on an accepted input beat.
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    len_d      = len_q;
    tlast_c    = 1'b0;
    short_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (s_hs) begin
          len_d = eff_len;
          if ((eff_len == LEN_WIDTH'(1)) || s_axis.tlast) begin
            tlast_c    = 1'b1;
            // One beat delivered; early only if more were expected.
            short_d    = s_axis.tlast && (eff_len != LEN_WIDTH'(1));
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = LEN_WIDTH'(1);
            state_d    = StInPkt;
          end
        end
      end
      StInPkt: begin
        if (s_hs) begin
          tlast_c = last_cnt || s_axis.tlast;
          if (tlast_c) begin
            // Source tlast on the natural last beat is not a short packet.
            short_d    = s_axis.tlast && !last_cnt;
            beat_cnt_d = '0;
            state_d    = StIdle;
          end else begin
            beat_cnt_d = beat_cnt_q + LEN_WIDTH'(1);
          end
        end
      end
      default: begin
        state_d    = StIdle;
        beat_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= StIdle;
      beat_cnt_q <= '0;
      len_q      <= '0;
      short_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      len_q      <= len_d;
      short_q    <= short_d;
    end
  end

  // Output register: load on input handshake, otherwise drain on output
  // handshake. Data and tlast only change on a load, so they hold under stall.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tdata_q  <= '0;
    end else if (s_hs) begin
      tvalid_q <= 1'b1;
      tlast_q  <= tlast_c;
      tdata_q  <= s_axis.tdata;
    end else if (m_hs) begin
      tvalid_q <= 1'b0;
    end
  end

`ifdef AXIS_FRAMER_STATS_EN
  logic [31:0] pkt_count_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pkt_count_q <= '0;
    end else if (m_hs && tlast_q) begin
      pkt_count_q <= pkt_count_q + 32'd1;
    end
  end

  assign pkt_count = pkt_count_q;
`else
  // Packet statistics are compiled out.
`endif

endmodule
